// File: rtl/chaos_pkg.sv
// chaos_pkg: shared types, widths and code-packing helper for the chaos keystream block
// Contents: KS_W/CODE_W widths, FSM state enum, pack_code() building {X,Y,Z,W}
package chaos_pkg;
    localparam int KS_W   = 32;
    localparam int CODE_W = 8;

    typedef enum logic [1:0] {IDLE, GRST, REQ, WAIT} chaos_state_e;

    function automatic logic [KS_W-1:0] pack_code(
        input logic [CODE_W-1:0] x,
        input logic [CODE_W-1:0] y,
        input logic [CODE_W-1:0] z,
        input logic [CODE_W-1:0] w
    );
        return {x, y, z, w};
    endfunction
endpackage

// File: rtl/chaos_keystream_xor_if.sv
// chaos_keystream_xor_if: valid/ready data-in and data-out streams of the keystream XOR block
// Signals: din/din_valid/din_ready (input stream), dout/dout_valid/dout_ready (output stream)
// Modports: slave = the XOR block, master = the stream source/sink around it
interface chaos_keystream_xor_if;
    import chaos_pkg::*;
    logic [KS_W-1:0] din;
    logic            din_valid;
    logic            din_ready;
    logic [KS_W-1:0] dout;
    logic            dout_valid;
    logic            dout_ready;

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );
endinterface

// File: rtl/chaos_ks_fifo.sv
// chaos_ks_fifo: DEPTH-word keystream FIFO with flush, level output and first-word-fall-through read
// Ports: clk, rst_n (async active-low), flush/push/pop controls, wdata in,
//        rdata (oldest word, valid while level != 0), level (occupancy 0..DEPTH)
module chaos_ks_fifo
    import chaos_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [KS_W-1:0] wdata,
    output logic [KS_W-1:0] rdata,
    output logic [AW:0]     level
);
    logic [KS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= wdata;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + (AW+1)'(push) - (AW+1)'(pop);
        end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/chaos_keystream_xor.sv
// chaos_keystream_xor: drives the chaos generator, buffers {X,Y,Z,W} keystream words and XORs them onto a stream
// Ports: clk, rst_n (async assert, sync release), start pulse + shift_cfg,
//        gen_step/gen_reset/gen_shift to the generator, gen_done + gen_x..gen_w from it,
//        s (slave stream: din in, dout out), ks_level (FIFO occupancy), timeout_err (sticky)
module chaos_keystream_xor
    import chaos_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int RESET_CYCLES = 2,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [KS_W-1:0]          shift_cfg,
    output logic                     gen_step,
    output logic                     gen_reset,
    output logic [KS_W-1:0]          gen_shift,
    input  logic                     gen_done,
    input  logic [CODE_W-1:0]        gen_x,
    input  logic [CODE_W-1:0]        gen_y,
    input  logic [CODE_W-1:0]        gen_z,
    input  logic [CODE_W-1:0]        gen_w,
    chaos_keystream_xor_if.slave     s,
    output logic [$clog2(DEPTH):0]   ks_level,
    output logic                     timeout_err
);
    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam int TO_W = $clog2(DONE_TIMEOUT + 1);

    chaos_state_e    state, state_nx;
    logic [1:0]      rst_sync;
    logic            rst_i;
    logic [RC_W-1:0] rst_cnt;
    logic [TO_W-1:0] tmo_cnt;
    logic            done_q;
    logic            step_nx;
    logic            push;
    logic            tmo_hit;
    logic            fire;
    logic            full;
    logic [KS_W-1:0] ks_word;

    // Reset asserts immediately and releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};

    assign rst_i     = rst_sync[1];
    assign full      = ks_level == LW'(DEPTH);
    assign gen_reset = state == GRST;
    assign s.din_ready = (ks_level != '0) && (!s.dout_valid || s.dout_ready);
    assign fire      = s.din_valid && s.din_ready && !start;

    always_ff @(posedge clk or negedge rst_i)
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;

    // START overrides every other event, including a DONE edge seen in WAIT.
    always_comb begin
        state_nx = state;
        step_nx  = 1'b0;
        push     = 1'b0;
        tmo_hit  = 1'b0;
        if (start) state_nx = GRST;
        else case (state)
            GRST: if (rst_cnt == RC_W'(RESET_CYCLES - 1)) state_nx = REQ;
            REQ: if (!full) begin
                step_nx  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (gen_done && !done_q) begin
                push     = 1'b1;
                state_nx = REQ;
            end else if (tmo_cnt == TO_W'(DONE_TIMEOUT - 1)) begin
                tmo_hit  = 1'b1;
                state_nx = REQ;
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i)
        if (!rst_i) begin
            gen_step     <= 1'b0;
            gen_shift    <= '0;
            timeout_err  <= 1'b0;
            done_q       <= 1'b0;
            rst_cnt      <= '0;
            tmo_cnt      <= '0;
            s.dout       <= '0;
            s.dout_valid <= 1'b0;
        end else begin
            gen_step     <= step_nx;
            gen_shift    <= start ? shift_cfg : gen_shift;
            timeout_err  <= !start && (timeout_err || tmo_hit);
            done_q       <= gen_done;
            rst_cnt      <= (state == GRST && !start) ? rst_cnt + 1'b1 : '0;
            tmo_cnt      <= (state == WAIT && state_nx == WAIT) ? tmo_cnt + 1'b1 : '0;
            s.dout       <= fire ? (s.din ^ ks_word) : s.dout;
            s.dout_valid <= !start && (fire || (s.dout_valid && !s.dout_ready));
        end

    chaos_ks_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_i),
        .flush (start),
        .push  (push),
        .pop   (fire),
        .wdata (pack_code(gen_x, gen_y, gen_z, gen_w)),
        .rdata (ks_word),
        .level (ks_level)
    );
endmodule

// File: tb/tb_chaos_keystream_xor.sv
// tb_chaos_keystream_xor: scoreboard bench for chaos_keystream_xor with a behavioural generator model
module tb_chaos_keystream_xor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] shift_cfg;
    logic        gen_step;
    logic        gen_reset;
    logic [31:0] gen_shift;
    logic        gen_done;
    logic [7:0]  gen_x, gen_y, gen_z, gen_w;
    logic [2:0]  ks_level;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;
    int mon_cnt = 0;
    int idx = 0;
    bit gen_en = 1'b0;
    bit drv_done = 1'b0;
    logic [31:0] exp_q [$];

    logic [31:0] ks_tab [8] = '{32'hA1B2C3D4, 32'h11223344, 32'h55667788, 32'h99AABBCC,
                                32'hDDEEFF00, 32'h01020304, 32'h0F0F0F0F, 32'hF0F0F0F0};
    logic [31:0] dv [6] = '{32'h00000000, 32'hFFFFFFFF, 32'h12345678,
                            32'hDDEEFF00, 32'h0000FFFF, 32'hF0F0F0F0};
    logic [31:0] ev [6] = '{32'h11223344, 32'hAA998877, 32'h8B9EEDB4,
                            32'h00000000, 32'h0102FCFB, 32'hFFFFFFFF};

    chaos_keystream_xor_if sif ();

    chaos_keystream_xor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .shift_cfg   (shift_cfg),
        .gen_step    (gen_step),
        .gen_reset   (gen_reset),
        .gen_shift   (gen_shift),
        .gen_done    (gen_done),
        .gen_x       (gen_x),
        .gen_y       (gen_y),
        .gen_z       (gen_z),
        .gen_w       (gen_w),
        .s           (sif),
        .ks_level    (ks_level),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] e);
        bit ok = 1'b0;
        sif.din = d;
        sif.din_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (sif.din_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1 sif.din_valid = 1'b0;
    endtask

    task automatic wait_level(input int lvl);
        for (int i = 0; i < 300 && 32'(ks_level) != lvl; i++) @(negedge clk);
        chk("ks_level_reach", 32'(ks_level), 32'(lvl));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Generator model: one code set, with gen_done high for a cycle, one cycle after each step.
    initial begin
        gen_done = 1'b0;
        {gen_x, gen_y, gen_z, gen_w} = '0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_reset) idx = 0;
            else if (gen_en && gen_step) begin
                @(posedge clk);
                #1;
                {gen_x, gen_y, gen_z, gen_w} = ks_tab[idx % 8];
                gen_done = 1'b1;
                @(posedge clk);
                #1 gen_done = 1'b0;
                idx++;
            end
        end
    end

    always @(negedge clk)
        if (rst_n && sif.dout_valid && sif.dout_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected", sif.dout, 32'hxxxxxxxx);
            else begin
                chk("sb_dout", sif.dout, exp_q.pop_front());
                mon_cnt++;
            end
        end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int hcnt;
        int n;
        bit found;
        logic [31:0] hold;
        int stepc;
        int dchg;
        rst_n = 1'b1;
        start = 1'b0;
        shift_cfg = '0;
        sif.din = '0;
        sif.din_valid = 1'b0;
        sif.dout_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gen_step", 32'(gen_step), 32'd0);
        chk("rst_gen_reset", 32'(gen_reset), 32'd0);
        chk("rst_din_ready", 32'(sif.din_ready), 32'd0);
        chk("rst_dout_valid", 32'(sif.dout_valid), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_gen_shift", gen_shift, 32'd0);
        chk("rst_dout", sif.dout, 32'd0);
        chk("rst_ks_level", 32'(ks_level), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        gen_en = 1'b1;
        repeat (4) @(posedge clk);

        #1 start = 1'b1;
        shift_cfg = 32'h12345678;
        @(posedge clk);
        #1 start = 1'b0;
        hcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!gen_reset) break;
            hcnt++;
        end
        chk("grst_cycles", 32'(hcnt), 32'd2);
        chk("gen_shift", gen_shift, 32'h12345678);
        chk("step_in_req", 32'(gen_step), 32'd0);
        @(negedge clk);
        chk("step_pulse", 32'(gen_step), 32'd1);
        @(negedge clk);
        chk("step_one_cycle", 32'(gen_step), 32'd0);
        wait_level(4);

        @(posedge clk);
        #1 sif.dout_ready = 1'b1;
        send(32'hFFFF0000, 32'h5E4DC3D4);
        @(negedge clk);
        chk("lat_dout_valid", 32'(sif.dout_valid), 32'd1);
        chk("lat_dout", sif.dout, 32'h5E4DC3D4);
        wait_drain();

        wait_level(4);
        @(posedge clk);
        #1 sif.dout_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(dv[i], ev[i]);
                drv_done = 1'b1;
            end
        join_none
        repeat (12) @(negedge clk);
        hold = sif.dout;
        stepc = 0;
        dchg = 0;
        repeat (15) begin
            @(negedge clk);
            if (gen_step) stepc++;
            if (sif.dout !== hold) dchg++;
        end
        chk("full_level", 32'(ks_level), 32'd4);
        chk("full_no_step", 32'(stepc), 32'd0);
        chk("hold_stable", 32'(dchg), 32'd0);
        chk("hold_valid", 32'(sif.dout_valid), 32'd1);
        chk("hold_dout", sif.dout, 32'h11223344);
        @(posedge clk);
        #1 sif.dout_ready = 1'b1;
        for (int i = 0; i < 300 && !drv_done; i++) @(negedge clk);
        chk("drv_done", 32'(drv_done), 32'd1);
        wait_drain();

        wait_level(4);
        @(posedge clk);
        #1 gen_en = 1'b0;
        send(32'h0F0F0F0F, 32'hFFFFFFFF);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = gen_step;
        end
        chk("step_after_pop", 32'(found), 32'd1);
        chk("tmo_clear", 32'(timeout_err), 32'd0);
        n = 0;
        for (int i = 0; i < 400 && !timeout_err; i++) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd255);
        @(negedge clk);
        chk("step_reissue", 32'(gen_step), 32'd1);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        chk("collide_din_ready", 32'(sif.din_ready), 32'd1);
        chk("collide_level_pre", 32'(ks_level), 32'd3);

        @(posedge clk);
        #1 start = 1'b1;
        shift_cfg = 32'hCAFEBABE;
        {gen_x, gen_y, gen_z, gen_w} = 32'h01234567;
        gen_done = 1'b1;
        sif.din = 32'h12345678;
        sif.din_valid = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        gen_done = 1'b0;
        sif.din_valid = 1'b0;
        gen_en = 1'b1;
        @(negedge clk);
        chk("collide_level", 32'(ks_level), 32'd0);
        chk("collide_dout_valid", 32'(sif.dout_valid), 32'd0);
        chk("collide_grst", 32'(gen_reset), 32'd1);
        chk("collide_shift", gen_shift, 32'hCAFEBABE);
        chk("collide_tmo_clr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        chk("collide_no_push", 32'(ks_level), 32'd0);
        chk("sb_total", 32'(mon_cnt), 32'd8);

        wait_level(4);
        @(posedge clk);
        #1 sif.dout_ready = 1'b0;
        send(32'h00000000, 32'hA1B2C3D4);
        @(negedge clk);
        chk("pre_rst_dout", sif.dout, 32'hA1B2C3D4);
        chk("pre_rst_valid", 32'(sif.dout_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dout_valid", 32'(sif.dout_valid), 32'd0);
        chk("arst_dout", sif.dout, 32'd0);
        chk("arst_ks_level", 32'(ks_level), 32'd0);
        chk("arst_gen_shift", gen_shift, 32'd0);
        chk("arst_din_ready", 32'(sif.din_ready), 32'd0);
        chk("arst_gen_reset", 32'(gen_reset), 32'd0);
        chk("arst_gen_step", 32'(gen_step), 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/chaos_keystream_xor.md
# chaos_keystream_xor

Downstream consumer of the chaos code generator. It drives the generator's STEP, RESET and SHIFT controls and collects each {X,Y,Z,W} byte set into a 32-bit keystream word. Words are buffered in a small FIFO, and each one is XORed with one word of a valid/ready data stream. It sits between the generator and the Nios-side or streaming data path, so data can be encrypted and decrypted without per-word software polling.

## Interface
- DEPTH, 4: keystream FIFO depth in words; power of two, ≥2.
- RESET_CYCLES, 2: cycles GEN_RESET is held high after START.
- DONE_TIMEOUT, 255: cycles waited for GEN_DONE before re-requesting.
- One clock; reset is asynchronous and active-low.
- CLK  in  1  system clock (50 MHz domain).
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse: latch SHIFT_CFG, reset generator, flush keystream.
- SHIFT_CFG  in  32  seed/shift value forwarded to generator.
- GEN_STEP  out  1  one-cycle request for the next code set.
- GEN_RESET  out  1  generator reset, active-high.
- GEN_SHIFT  out  32  registered copy of SHIFT_CFG.
- GEN_DONE  in  1  generator code-valid indication; its rising edge is used.
- GEN_X, GEN_Y, GEN_Z, GEN_W  in  8 each  generator code outputs.
- DIN  in  32, DIN_VALID  in  1, DIN_READY  out  1  plaintext/ciphertext input stream.
- DOUT  out  32, DOUT_VALID  out  1, DOUT_READY  in  1  XORed output stream.
- KS_LEVEL  out  $clog2(DEPTH)+1  keystream FIFO occupancy.
- TIMEOUT_ERR  out  1  sticky; set when a GEN_DONE wait times out; cleared by START.

## Operation
- Reset values:
  - GEN_STEP, GEN_RESET, DIN_READY, DOUT_VALID, TIMEOUT_ERR = 0.
  - GEN_SHIFT, DOUT = 0; KS_LEVEL = 0.
  - FSM in IDLE.
- Keystream word packing: {GEN_X, GEN_Y, GEN_Z, GEN_W}, with X in [31:24] and W in [7:0].
- FSM states and transitions:
  - IDLE: outputs quiet. START → GRST.
  - GRST: GEN_RESET=1 for RESET_CYCLES cycles; GEN_SHIFT takes SHIFT_CFG on START. Then → REQ.
  - REQ: if FIFO not full, GEN_STEP=1 for exactly one cycle → WAIT. Otherwise stay in REQ.
  - WAIT: on a GEN_DONE rising edge (GEN_DONE=1 and the previous registered value 0), push the packed word → REQ. After DONE_TIMEOUT cycles with no edge, set TIMEOUT_ERR → REQ (re-request, no push).
- START in any state:
  - flushes the FIFO;
  - clears DOUT_VALID and TIMEOUT_ERR;
  - discards any pending DONE;
  - goes to GRST.
  - START has priority over every other event in that cycle.
- GEN_DONE edges outside WAIT are ignored.
- XOR stage:
  - DIN_READY = FIFO non-empty and (!DOUT_VALID or DOUT_READY).
  - On DIN_VALID & DIN_READY: pop one keystream word; DOUT ← DIN ^ word; DOUT_VALID ← 1.
  - On DOUT_VALID & DOUT_READY with no new fire: DOUT_VALID ← 0.
  - DOUT holds stable while DOUT_VALID & !DOUT_READY.
- Push and pop in the same cycle are legal: KS_LEVEL is unchanged, and the popped word is the oldest.
- FIFO full: no GEN_STEP is issued, so a push to a full FIFO cannot occur.
- FIFO empty: DIN_READY=0.

## Timing
- GEN_STEP rises exactly 1 cycle after REQ is entered with FIFO not full.
- Push occurs the cycle after the GEN_DONE rising edge is sampled, so the word is visible in KS_LEVEL 1 cycle later.
- DIN to DOUT latency: 1 cycle, with full throughput (one word per cycle) while the FIFO is non-empty and DOUT_READY=1.
- First keystream after START: RESET_CYCLES + 1 (REQ) + generator latency + 1 cycles.
- RESET_N is asserted asynchronously and released synchronously to CLK, via a two-flop release synchronizer inside the block.

## Structure
- Shared package chaos_pkg:
  - FSM state enum (IDLE, GRST, REQ, WAIT);
  - KS_W=32, CODE_W=8 constants;
  - packing function for {X,Y,Z,W}.
- One sub-module, chaos_ks_fifo:
  - synchronous DEPTH-word FIFO with push/pop/flush and level output;
  - first-word-fall-through read data.
- Top contains the FSM, DONE edge detector, timeout counter and XOR output register.

## Test plan
- Reset then START with SHIFT_CFG=32'h1234_5678 → GEN_RESET high 2 cycles, GEN_SHIFT=32'h1234_5678, GEN_STEP pulses once.
- Generator model returns X,Y,Z,W = 8'hA1,8'hB2,8'hC3,8'hD4; DIN=32'hFFFF_0000 → DOUT=32'h5E4D_C3D4 one cycle after the handshake.
- DOUT_READY=0 with 6 words offered and DEPTH=4 → KS_LEVEL saturates at 4, no GEN_STEP while full, DOUT stable; release DOUT_READY → all words emerge in order.
- GEN_DONE never rises → TIMEOUT_ERR set after 255 WAIT cycles, GEN_STEP re-issued on the next cycle.
- START asserted in the same cycle as a GEN_DONE rising edge and a DIN fire → FIFO empty, DOUT_VALID=0, no push, FSM in GRST.
- RESET_N dropped mid-stream → all outputs return to their reset values immediately, before the next CLK edge.
